// File: rtl/tile_pkg.sv
// Shared tile-grid geometry and cell types, used by the scanner, the board logic and the glyph ROM.
package tile_pkg;

  localparam int TILE_LOG2 = 6;
  localparam int GRID_LOG2 = 2;
  localparam int GRID_PX   = 256;

  typedef logic [3:0] cell_addr_t;
  typedef logic [3:0] tile_exp_t;

  function automatic cell_addr_t cell_addr(input logic [GRID_LOG2-1:0] row,
                                           input logic [GRID_LOG2-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/grid_tile_scanner_if.sv
// Tile coordinate bus from the scanner (master) to the glyph ROM lookup (slave).
interface grid_tile_scanner_if;
  import tile_pkg::*;

  // Handshake: tile_valid qualifies tile_index/tile_x/tile_y for exactly one pixel
  // clock. There is no ready; the consumer must accept every beat at pixel rate.
  tile_exp_t            tile_index;
  logic [TILE_LOG2-1:0] tile_x;
  logic [TILE_LOG2-1:0] tile_y;
  logic                 tile_valid;

  modport master (output tile_index, output tile_x, output tile_y, output tile_valid);
  modport slave  (input  tile_index, input  tile_x, input  tile_y, input  tile_valid);

endinterface

// File: rtl/tile_axis_counter.sv
// One axis of the board scan: pixel-in-tile counter, tile counter and an active flag.
module tile_axis_counter
  import tile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 step,
  input  logic                 clr,
  output logic [TILE_LOG2-1:0] local_cnt,
  output logic [GRID_LOG2-1:0] tile_cnt,
  output logic                 active,
  output logic                 last
);

  localparam logic [TILE_LOG2-1:0] LOCAL_MAX = '1;
  localparam logic [GRID_LOG2-1:0] TILE_MAX  = '1;

  assign last = active && (tile_cnt == TILE_MAX) && (local_cnt == LOCAL_MAX);

  // Arm wins over everything; step and clr may coincide so the final step wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      local_cnt <= '0;
      tile_cnt  <= '0;
      active    <= 1'b0;
    end else if (arm) begin
      local_cnt <= '0;
      tile_cnt  <= '0;
      active    <= 1'b1;
    end else begin
      if (step && active) begin
        local_cnt <= local_cnt + 1'b1;
        if (local_cnt == LOCAL_MAX) tile_cnt <= tile_cnt + 1'b1;
      end
      if (clr) active <= 1'b0;
    end
  end

endmodule

// File: rtl/grid_tile_scanner.sv
// Maps the beam position onto the 4x4 board: cell address for the board regfile and
// registered per-pixel tile coordinates for the glyph ROM.
module grid_tile_scanner
  import tile_pkg::*;
#(
  parameter int GRID_X0 = 192,
  parameter int GRID_Y0 = 112
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  de,
  output cell_addr_t            board_addr,
  input  tile_exp_t             board_val,
  grid_tile_scanner_if.master   tile
);

  localparam logic [9:0] ARM_H = 10'(GRID_X0 - 1);
  localparam logic [9:0] ARM_V = 10'(GRID_Y0 - 1);

  logic                 de_q;
  logic                 de_fall;

  logic [TILE_LOG2-1:0] cx, cy;
  logic [GRID_LOG2-1:0] col, row;
  logic                 h_act, v_act;
  logic                 h_last, v_last;

  logic                 h_arm, h_clr;
  logic                 v_arm, v_clr;

  assign de_fall = de_q && !de;

  assign h_arm = de && (hpos == ARM_H);
  assign h_clr = !de || h_last;

  // Vertical state moves only at line end; resync at line 0 is overridden by arming.
  assign v_arm = de_fall && (vpos == ARM_V);
  assign v_clr = de_fall && ((vpos == 10'd0) || v_last);

  tile_axis_counter u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .arm       (h_arm),
    .step      (de),
    .clr       (h_clr),
    .local_cnt (cx),
    .tile_cnt  (col),
    .active    (h_act),
    .last      (h_last)
  );

  tile_axis_counter u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .arm       (v_arm),
    .step      (de_fall),
    .clr       (v_clr),
    .local_cnt (cy),
    .tile_cnt  (row),
    .active    (v_act),
    .last      (v_last)
  );

  assign board_addr = cell_addr(row, col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q <= 1'b0;
    end else begin
      de_q <= de;
    end
  end

  // Single output stage; board_val is the same-cycle answer for board_addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile.tile_valid <= 1'b0;
      tile.tile_index <= '0;
      tile.tile_x     <= '0;
      tile.tile_y     <= '0;
    end else if (de && h_act && v_act) begin
      tile.tile_valid <= 1'b1;
      tile.tile_index <= board_val;
      tile.tile_x     <= cx;
      tile.tile_y     <= cy;
    end else begin
      tile.tile_valid <= 1'b0;
      tile.tile_index <= '0;
      tile.tile_x     <= '0;
      tile.tile_y     <= '0;
    end
  end

endmodule

// File: tb/tb_grid_tile_scanner.sv
// Directed bench for grid_tile_scanner with GRID_X0=192, GRID_Y0=112 and a board returning addr+1.
module tb_grid_tile_scanner;
  import tile_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       de;
  cell_addr_t board_addr;
  tile_exp_t  board_val;

  grid_tile_scanner_if tile_if ();

  grid_tile_scanner #(.GRID_X0(192), .GRID_Y0(112)) dut (
    .clk        (clk),
    .rst        (rst),
    .hpos       (hpos),
    .vpos       (vpos),
    .de         (de),
    .board_addr (board_addr),
    .board_val  (board_val),
    .tile       (tile_if.master)
  );

  // clock / board model
  always #5 clk = ~clk;
  assign board_val = board_addr + 4'd1;

  int checks = 0;
  int errors = 0;

  int obs_valid [0:1023];
  int obs_idx   [0:1023];
  int obs_x     [0:1023];
  int obs_y     [0:1023];
  int obs_addr  [0:1023];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One line: de=1 for hpos 0..hend-1, then two blanking pixels. board_addr is
  // sampled while the pixel is on hpos; outputs are sampled after its clock edge.
  task automatic run_line(input int v, input int hend, input int rst_at);
    for (int h = 0; h < hend + 2; h++) begin
      @(negedge clk);
      hpos = 10'(h);
      vpos = 10'(v);
      de   = (h < hend);
      rst  = (h == rst_at);
      #1 obs_addr[h] = int'(board_addr);
      @(posedge clk);
      #1;
      obs_valid[h] = int'(tile_if.tile_valid);
      obs_idx[h]   = int'(tile_if.tile_index);
      obs_x[h]     = int'(tile_if.tile_x);
      obs_y[h]     = int'(tile_if.tile_y);
    end
  endtask

  function automatic int count_valid(input int lo, input int hi);
    int n = 0;
    for (int h = lo; h <= hi; h++) n += obs_valid[h];
    return n;
  endfunction

  initial begin
    // reset mid-line
    rst = 1'b1; hpos = 10'd300; vpos = 10'd150; de = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(tile_if.tile_valid), 0);
    check("rst_index", int'(tile_if.tile_index), 0);
    check("rst_x",     int'(tile_if.tile_x), 0);
    check("rst_y",     int'(tile_if.tile_y), 0);
    check("rst_addr",  int'(board_addr), 0);
    @(negedge clk);
    rst = 1'b0; de = 1'b0; hpos = 10'd0; vpos = 10'd0;

    // frame 1
    for (int v = 0; v < 480; v++) begin
      if (v == 112) begin
        run_line(v, 460, -1);
        check("f1_pre_valid",   obs_valid[191], 0);
        check("f1_first_valid", obs_valid[192], 1);
        check("f1_first_index", obs_idx[192], 1);
        check("f1_first_x",     obs_x[192], 0);
        check("f1_first_y",     obs_y[192], 0);
        check("c0_end_addr",    obs_addr[255], 0);
        check("c0_end_x",       obs_x[255], 63);
        check("c1_start_addr",  obs_addr[256], 1);
        check("c1_start_x",     obs_x[256], 0);
        check("c1_start_index", obs_idx[256], 2);
        check("c3_end_addr",    obs_addr[447], 3);
        check("c3_end_x",       obs_x[447], 63);
        check("c3_end_valid",   obs_valid[447], 1);
        check("right_valid",    obs_valid[448], 0);
        check("blank_valid",    obs_valid[460], 0);
      end else if (v == 175) begin
        run_line(v, 460, -1);
        check("r0_end_y",    obs_y[200], 63);
        check("r0_end_addr", obs_addr[200], 0);
      end else if (v == 176) begin
        run_line(v, 460, -1);
        check("r1_start_y",      obs_y[200], 0);
        check("r1_start_addr",   obs_addr[200], 4);
        check("r1_last_addr",    obs_addr[447], 7);
        check("r1_last_index",   obs_idx[447], 8);
      end else if (v == 177) begin
        run_line(v, 300, -1);
        check("trunc_last_valid", obs_valid[299], 1);
        check("trunc_last_x",     obs_x[299], 43);
        check("trunc_last_addr",  obs_addr[299], 5);
        check("trunc_drop_valid", obs_valid[300], 0);
      end else if (v == 178) begin
        run_line(v, 460, -1);
        check("after_trunc_x",     obs_x[192], 0);
        check("after_trunc_y",     obs_y[192], 2);
        check("after_trunc_addr",  obs_addr[192], 4);
        check("after_trunc_valid", obs_valid[192], 1);
      end else if (v == 367) begin
        run_line(v, 460, -1);
        check("r3_end_y",      obs_y[250], 63);
        check("r3_end_addr",   obs_addr[250], 12);
        check("r3_last_addr",  obs_addr[447], 15);
        check("r3_last_index", obs_idx[447], 0);
        check("r3_last_valid", obs_valid[447], 1);
      end else if (v == 368) begin
        run_line(v, 460, -1);
        check("below_valid_cnt", count_valid(0, 461), 0);
      end else begin
        run_line(v, 4, -1);
      end
    end

    // frame 2: reset in the middle of line 200
    for (int v = 0; v < 480; v++) begin
      if (v == 200) begin
        run_line(v, 460, 300);
        check("pre_rst_valid",   obs_valid[250], 1);
        check("pre_rst_y",       obs_y[250], 24);
        check("post_rst_cnt",    count_valid(300, 461), 0);
      end else if (v == 201) begin
        run_line(v, 460, -1);
        check("rst_frame_cnt",   count_valid(0, 461), 0);
      end else if (v == 300) begin
        run_line(v, 460, -1);
        check("rst_frame_cnt2",  count_valid(0, 461), 0);
      end else begin
        run_line(v, 4, -1);
      end
    end

    // frame 3: board returns after the reset frame
    for (int v = 0; v < 113; v++) begin
      if (v == 112) begin
        run_line(v, 460, -1);
        check("f3_pre_valid",   obs_valid[191], 0);
        check("f3_first_valid", obs_valid[192], 1);
        check("f3_first_index", obs_idx[192], 1);
        check("f3_first_x",     obs_x[192], 0);
      end else begin
        run_line(v, 4, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
